sd_digit_collector_div: RTL and testbench
=========================================

// Module: sd_digit_collector_div
// PURPOSE
//  Receiving end of the divider's quotient digit stream. Accepts MSD-first radix-2 signed digits
//  (q_value, valid/ready) and converts them on the fly (Q/QM registers, no carry-propagate add).
//  After NUM_DIGITS digits it presents one two's-complement integer result under a valid/ready
//  handshake. Sits between Divider_hd data_out_* and any conventional-binary consumer.
// PARAMETERS
//  NUM_DIGITS   32  digits per result (after skipped digits); result width NUM_DIGITS+1
//  SKIP_DIGITS  0   leading digits accepted and discarded per operation (divider online delay)
//  CNT_WIDTH    7   digit counter width; must hold NUM_DIGITS+SKIP_DIGITS
// PORTS
//  clk         in   1             single clock, all state on rising edge
//  asyn_reset  in   1             synchronous, active-low reset (legacy name; NOT asynchronous)
//  q_value     in   2             signed digit {plus,minus}: 10=+1, 01=-1, 00=0, 11=illegal
//  q_vld       in   1             q_value valid
//  q_rdy       out  1             collector can accept a digit
//  result      out  NUM_DIGITS+1  two's-complement sum of q_i*2^(NUM_DIGITS-1-i)
//  result_vld  out  1             result valid
//  result_rdy  in   1             consumer accepts result
//  digit_err   out  1             at least one illegal digit (11) in this result's stream
// BEHAVIOUR
//  Reset: asyn_reset==0 at a clock edge -> state COLLECT, cnt=0, Q=0, QM=all ones (-1),
//   result=0, result_vld=0, digit_err=0, err_acc=0. Reset wins over every other event,
//   including mid-stream or while result_vld=1 (partial stream and pending result dropped).
//   q_rdy is 0 while asyn_reset==0.
//  Digit accepted iff q_vld & q_rdy at the clock edge. Never accepted when q_rdy=0.
//  States:
//   COLLECT: q_rdy=1, result_vld=0. On each accept: cnt<=cnt+1.
//     cnt < SKIP_DIGITS: digit discarded (Q/QM unchanged); an illegal 11 still sets err_acc.
//     otherwise, on-the-fly update, with d = plus-minus (11 treated as 0, sets err_acc):
//       d=+1: Q<={Q,1}   QM<={Q,0}
//       d= 0: Q<={Q,0}   QM<={QM,1}
//       d=-1: Q<={QM,1}  QM<={QM,0}
//     Shifts drop the MSB; Q/QM are NUM_DIGITS+1 bits. The value fits because
//      |result| <= 2^NUM_DIGITS-1.
//     On the accept with cnt == NUM_DIGITS+SKIP_DIGITS-1: the same edge sets result to the
//      updated Q, digit_err to err_acc (including this digit), result_vld<=1, -> DONE.
//      Latency is 1 cycle from the last accept to result_vld.
//   DONE: q_rdy=0, result/digit_err held stable while result_vld=1.
//     result_vld & result_rdy: result_vld<=0, cnt<=0, Q<=0, QM<=-1, err_acc<=0, -> COLLECT.
//     q_rdy returns to 1 the next cycle. There is no same-cycle accept of a new digit.
//     result_rdy=0: held indefinitely. Upstream stalls on q_rdy=0.
//  q_vld may drop between digits (bubbles): state is unchanged on non-accept cycles.
//  result_rdy while result_vld=0: ignored. q_value is don't-care when q_vld=0.
//  Outputs are registered. q_rdy is decoded from the state register only (no input->output path).
// TESTING
//  Reset: hold asyn_reset=0 for 3 cycles mid-stream -> result=0, result_vld=0, digit_err=0,
//   q_rdy=0 during reset, q_rdy=1 the next cycle. The following stream decodes from scratch.
//  NUM_DIGITS=4, digits +1,0,-1,+1 back-to-back (8-2+1) -> result=5'b00111, result_vld
//   rises 1 cycle after the 4th accept, digit_err=0.
//  NUM_DIGITS=4, digits -1,-1,-1,-1 -> result=5'b10001 (-15). Digits +1,-1,-1,-1 -> 5'b00001.
//  Backpressure: result_rdy=0 for 10 cycles with q_vld=1 -> result held, q_rdy=0, no digits
//   consumed. Then result_rdy=1 -> one handshake, and the next stream's first digit is
//   accepted 1 cycle later.
//  Random q_vld bubbles (20% duty) over 100 random streams -> results match a reference
//   model. One stream containing 11 -> that digit weighs 0 and digit_err=1; the next
//   stream has digit_err=0.
//  SKIP_DIGITS=2, NUM_DIGITS=4: 11,+1 then +1,0,0,-1 -> result=5'b00111, digit_err=1
//   (error in a skipped digit still counts).

Source files
------------

// File: rtl/sd_digit_collector_div_if.sv
`default_nettype none
// ============================================================================
// Module   : sd_digit_collector_div_if
// Purpose  : Digit-stream input and binary-result output handshakes of the
//            signed-digit quotient collector.
// Revision : 1.0
// ============================================================================
interface sd_digit_collector_div_if #(
  parameter int NUM_DIGITS = 32
);
  logic [1:0]          q_value;
  logic                q_vld;
  logic                q_rdy;
  logic [NUM_DIGITS:0] result;
  logic                result_vld;
  logic                result_rdy;
  logic                digit_err;

  modport master (
    output q_value, q_vld, result_rdy,
    input  q_rdy, result, result_vld, digit_err
  );

  modport slave (
    input  q_value, q_vld, result_rdy,
    output q_rdy, result, result_vld, digit_err
  );
endinterface
`default_nettype wire

// File: rtl/sd_digit_collector_div.sv
`default_nettype none
// ============================================================================
// Module   : sd_digit_collector_div
// Purpose  : On-the-fly conversion of an MSD-first radix-2 signed-digit
//            quotient stream into one two's-complement result per operation.
// Revision : 1.0
// ============================================================================
module sd_digit_collector_div #(
  parameter int NUM_DIGITS  = 32,
  parameter int SKIP_DIGITS = 0,
  parameter int CNT_WIDTH   = 7
) (
  input  wire logic               clk,
  input  wire logic               asyn_reset,
  sd_digit_collector_div_if.slave io_sd
);
  localparam int                 c_W    = NUM_DIGITS + 1;
  localparam logic [CNT_WIDTH-1:0] c_LAST = CNT_WIDTH'(NUM_DIGITS + SKIP_DIGITS - 1);

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_DONE    = 1'b1
  } state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [c_W-1:0]       r_q;
  logic [c_W-1:0]       r_qm;
  logic [c_W-1:0]       r_result;
  logic                 r_result_vld;
  logic                 r_digit_err;
  logic                 r_err_acc;
  logic                 r_q_rdy;

  logic                 w_plus;
  logic                 w_minus;
  logic                 w_illegal;
  logic                 w_accept;
  logic                 w_skip;
  logic                 w_last;
  logic                 w_err_now;
  logic [c_W-1:0]       w_q_nxt;
  logic [c_W-1:0]       w_qm_nxt;

  generate
    if (SKIP_DIGITS == 0) begin : g_no_skip
      assign w_skip = 1'b0;
    end else begin : g_skip
      assign w_skip = (r_cnt < CNT_WIDTH'(SKIP_DIGITS));
    end
  endgenerate

  assign w_plus    = io_sd.q_value[1] & ~io_sd.q_value[0];
  assign w_minus   = ~io_sd.q_value[1] & io_sd.q_value[0];
  assign w_illegal = &io_sd.q_value;
  assign w_accept  = io_sd.q_vld & r_q_rdy;
  assign w_last    = (r_cnt == c_LAST);
  assign w_err_now = r_err_acc | w_illegal;

  // Q holds the value so far and QM holds Q-1, so every digit is a pure shift/select.
  always_comb begin
    w_q_nxt  = {r_q[c_W-2:0], 1'b0};
    w_qm_nxt = {r_qm[c_W-2:0], 1'b1};
    if (w_plus) begin
      w_q_nxt  = {r_q[c_W-2:0], 1'b1};
      w_qm_nxt = {r_q[c_W-2:0], 1'b0};
    end else if (w_minus) begin
      w_q_nxt  = {r_qm[c_W-2:0], 1'b1};
      w_qm_nxt = {r_qm[c_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!asyn_reset) begin
      r_state      <= S_COLLECT;
      r_cnt        <= '0;
      r_q          <= '0;
      r_qm         <= '1;
      r_result     <= '0;
      r_result_vld <= 1'b0;
      r_digit_err  <= 1'b0;
      r_err_acc    <= 1'b0;
      r_q_rdy      <= 1'b0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          r_q_rdy <= 1'b1;
          if (w_accept) begin
            r_cnt     <= r_cnt + CNT_WIDTH'(1);
            r_err_acc <= w_err_now;
            if (!w_skip) begin
              r_q  <= w_q_nxt;
              r_qm <= w_qm_nxt;
            end
            if (w_last) begin
              r_result     <= w_q_nxt;
              r_digit_err  <= w_err_now;
              r_result_vld <= 1'b1;
              r_q_rdy      <= 1'b0;
              r_state      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (r_result_vld && io_sd.result_rdy) begin
            r_result_vld <= 1'b0;
            r_cnt        <= '0;
            r_q          <= '0;
            r_qm         <= '1;
            r_err_acc    <= 1'b0;
            r_q_rdy      <= 1'b1;
            r_state      <= S_COLLECT;
          end
        end
        default: begin
          r_state <= S_COLLECT;
          r_q_rdy <= 1'b0;
        end
      endcase
    end
  end

  assign io_sd.q_rdy      = r_q_rdy;
  assign io_sd.result     = r_result;
  assign io_sd.result_vld = r_result_vld;
  assign io_sd.digit_err  = r_digit_err;
endmodule
`default_nettype wire

// File: tb/tb_sd_digit_collector_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_digit_collector_div
// Purpose  : Randomized and directed checks of the signed-digit collector
//            (NUM_DIGITS=4, with and without skipped leading digits).
// Revision : 1.0
// ============================================================================
module tb_sd_digit_collector_div;
  localparam int ND = 4;
  localparam int W  = ND + 1;

  logic clk = 1'b0;
  logic asyn_reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sd_digit_collector_div_if #(.NUM_DIGITS(ND)) bus_a ();
  sd_digit_collector_div_if #(.NUM_DIGITS(ND)) bus_b ();

  sd_digit_collector_div #(.NUM_DIGITS(ND), .SKIP_DIGITS(0), .CNT_WIDTH(7)) u_dut_a (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .io_sd      (bus_a.slave)
  );

  sd_digit_collector_div #(.NUM_DIGITS(ND), .SKIP_DIGITS(2), .CNT_WIDTH(7)) u_dut_b (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .io_sd      (bus_b.slave)
  );

  // Reference: weighted sum of digits after the skipped prefix, wrapped to W bits.
  function automatic logic [W-1:0] ref_value(input logic [1:0] ds[$], input int skip);
    int acc = 0;
    for (int k = skip; k < ds.size(); k++) begin
      int wgt = 1 << (ds.size() - 1 - k);
      if (ds[k] == 2'b10) acc += wgt;
      else if (ds[k] == 2'b01) acc -= wgt;
    end
    return W'(acc);
  endfunction

  function automatic logic ref_err(input logic [1:0] ds[$]);
    foreach (ds[k]) if (ds[k] == 2'b11) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] rand_digit();
    int r = $urandom_range(0, 2);
    return (r == 0) ? 2'b10 : (r == 1) ? 2'b01 : 2'b00;
  endfunction

  function automatic logic get_rdy(input bit sel);
    return sel ? bus_b.q_rdy : bus_a.q_rdy;
  endfunction

  function automatic logic get_vld(input bit sel);
    return sel ? bus_b.result_vld : bus_a.result_vld;
  endfunction

  function automatic logic [W-1:0] get_res(input bit sel);
    return sel ? bus_b.result : bus_a.result;
  endfunction

  function automatic logic get_err(input bit sel);
    return sel ? bus_b.digit_err : bus_a.digit_err;
  endfunction

  task automatic drive(input bit sel, input logic [1:0] v, input logic vld);
    if (sel) begin
      bus_b.q_value = v;
      bus_b.q_vld   = vld;
    end else begin
      bus_a.q_value = v;
      bus_a.q_vld   = vld;
    end
  endtask

  task automatic set_rrdy(input bit sel, input logic v);
    if (sel) bus_b.result_rdy = v;
    else     bus_a.result_rdy = v;
  endtask

  task automatic send_digit(input bit sel, input logic [1:0] v, output bit ok);
    ok = 1'b0;
    drive(sel, v, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (get_rdy(sel)) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    drive(sel, 2'($urandom), 1'b0);
  endtask

  task automatic send_stream(input bit sel, input logic [1:0] ds[$], input bit bubbles,
                             output bit ok);
    bit okd;
    ok = 1'b1;
    foreach (ds[k]) begin
      while (bubbles && $urandom_range(0, 4) == 0) begin
        drive(sel, 2'($urandom), 1'b0);
        @(posedge clk);
        #1;
      end
      send_digit(sel, ds[k], okd);
      ok &= okd;
    end
  endtask

  task automatic take_result(input bit sel, output bit ok, output logic [W-1:0] res,
                             output logic err);
    ok  = 1'b0;
    res = 'x;
    err = 1'bx;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (get_vld(sel)) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      res = get_res(sel);
      err = get_err(sel);
      set_rrdy(sel, 1'b1);
      @(posedge clk);
      #1;
      set_rrdy(sel, 1'b0);
    end
  endtask

  task automatic check_stream(input string name, input bit sel, input logic [1:0] ds[$],
                              input int skip, input bit bubbles);
    bit ok_s, ok_r;
    logic [W-1:0] res;
    logic err;
    logic [W-1:0] exp_res = ref_value(ds, skip);
    logic exp_err = ref_err(ds);
    send_stream(sel, ds, bubbles, ok_s);
    take_result(sel, ok_r, res, err);
    n_checks++;
    if (!(ok_s && ok_r)) begin
      n_fail++;
      $display("FAIL %s handshake timeout: send_ok=%0b result_ok=%0b required 1/1", name, ok_s, ok_r);
    end
    n_checks++;
    if (res !== exp_res) begin
      n_fail++;
      $display("FAIL %s result: got %b required %b", name, res, exp_res);
    end
    n_checks++;
    if (err !== exp_err) begin
      n_fail++;
      $display("FAIL %s digit_err: got %b required %b", name, err, exp_err);
    end
  endtask

  task automatic test_reset();
    asyn_reset = 1'b0;
    drive(1'b0, 2'b00, 1'b0);
    drive(1'b1, 2'b00, 1'b0);
    set_rrdy(1'b0, 1'b0);
    set_rrdy(1'b1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus_a.q_rdy, bus_a.result_vld, bus_a.result, bus_a.digit_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b vld=%b res=%b err=%b required all 0",
               bus_a.q_rdy, bus_a.result_vld, bus_a.result, bus_a.digit_err);
    end
    #1 asyn_reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus_a.q_rdy !== 1'b1 || bus_b.q_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_rdy: a=%b b=%b required 1", bus_a.q_rdy, bus_b.q_rdy);
    end
  endtask

  task automatic test_reset_midstream();
    bit ok;
    logic [1:0] ds[$];
    send_digit(1'b0, 2'b10, ok);
    send_digit(1'b0, 2'b10, ok);
    asyn_reset = 1'b0;
    drive(1'b0, 2'b10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus_a.q_rdy !== 1'b0 || bus_a.result_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_cycle%0d: rdy=%b vld=%b required 0/0", i, bus_a.q_rdy,
                 bus_a.result_vld);
      end
    end
    drive(1'b0, 2'b00, 1'b0);
    asyn_reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus_a.q_rdy !== 1'b1 || bus_a.result !== '0 || bus_a.digit_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_after: rdy=%b res=%b err=%b required 1/00000/0", bus_a.q_rdy,
               bus_a.result, bus_a.digit_err);
    end
    ds = '{2'b01, 2'b00, 2'b00, 2'b10};
    check_stream("reset_fresh_stream", 1'b0, ds, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [1:0] ds[$] = '{2'b10, 2'b00, 2'b01, 2'b10};
    foreach (ds[k]) begin
      drive(1'b0, ds[k], 1'b1);
      @(negedge clk);
      n_checks++;
      if (bus_a.q_rdy !== 1'b1 || bus_a.result_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_digit%0d: rdy=%b vld=%b required 1/0", k, bus_a.q_rdy, bus_a.result_vld);
      end
      @(posedge clk);
      #1;
    end
    drive(1'b0, 2'b00, 1'b0);
    @(negedge clk);
    n_checks++;
    if (bus_a.result_vld !== 1'b1 || bus_a.result !== 5'b00111 || bus_a.digit_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_result: vld=%b res=%b err=%b required 1/00111/0", bus_a.result_vld,
               bus_a.result, bus_a.digit_err);
    end
    bus_a.result_rdy = 1'b1;
    @(posedge clk);
    #1 bus_a.result_rdy = 1'b0;
  endtask

  task automatic test_vectors();
    logic [1:0] ds[$];
    ds = '{2'b01, 2'b01, 2'b01, 2'b01};
    check_stream("all_minus", 1'b0, ds, 0, 1'b0);
    ds = '{2'b10, 2'b01, 2'b01, 2'b01};
    check_stream("plus_then_minus", 1'b0, ds, 0, 1'b0);
    ds = '{2'b10, 2'b10, 2'b10, 2'b10};
    check_stream("all_plus", 1'b0, ds, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [1:0] ds[$];
    logic [1:0] nx[$];
    logic [W-1:0] exp_res;
    for (int k = 0; k < ND; k++) ds.push_back(rand_digit());
    for (int k = 0; k < ND; k++) nx.push_back(rand_digit());
    exp_res = ref_value(ds, 0);
    send_stream(1'b0, ds, 1'b0, ok);
    drive(1'b0, nx[0], 1'b1);
    bus_a.result_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus_a.q_rdy !== 1'b0 || bus_a.result_vld !== 1'b1 || bus_a.result !== exp_res) begin
        n_fail++;
        $display("FAIL backpressure_hold%0d: rdy=%b vld=%b res=%b required 0/1/%b", i,
                 bus_a.q_rdy, bus_a.result_vld, bus_a.result, exp_res);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus_a.result_rdy = 1'b1;
    @(posedge clk);
    #1 bus_a.result_rdy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus_a.q_rdy !== 1'b1 || bus_a.result_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: rdy=%b vld=%b required 1/0", bus_a.q_rdy,
               bus_a.result_vld);
    end
    @(posedge clk);
    #1;
    drive(1'b0, 2'b00, 1'b0);
    begin
      logic [1:0] rest[$] = nx[1:$];
      bit ok_s, ok_r;
      logic [W-1:0] res;
      logic err;
      send_stream(1'b0, rest, 1'b0, ok_s);
      take_result(1'b0, ok_r, res, err);
      n_checks++;
      if (!ok_s || !ok_r || res !== ref_value(nx, 0) || err !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_next_stream: res=%b err=%b required %b/0", res, err,
                 ref_value(nx, 0));
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] ds[$];
    for (int s = 0; s < 100; s++) begin
      ds.delete();
      for (int k = 0; k < ND; k++) ds.push_back(rand_digit());
      if (s == 37) ds[$urandom_range(0, ND - 1)] = 2'b11;
      check_stream($sformatf("random_stream%0d", s), 1'b0, ds, 0, 1'b1);
    end
  endtask

  task automatic test_skip();
    logic [1:0] ds[$];
    ds = '{2'b11, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01};
    check_stream("skip_err", 1'b1, ds, 2, 1'b0);
    ds = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
    check_stream("skip_clean", 1'b1, ds, 2, 1'b1);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_vectors();
    test_reset_midstream();
    test_backpressure();
    test_random();
    test_skip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
